bcd_event_counter: RTL

BCD_EVENT_COUNTER -- requirements
Module: bcd_event_counter

---
 rtl/bcd_event_counter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bcd_event_counter.sv
// Three-digit BCD up/down counter stepped by a prescaler tick or a push button.
// Define BCD_EVENT_COUNTER_DEBOUNCE_EN to add a stability filter on the button.
module bcd_event_counter #(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       run,
  input  logic       up_down,
  input  logic       clear,
  input  logic       step_btn_n,
  output logic [3:0] unites,
  output logic [3:0] dizaines,
  output logic [3:0] centaines,
  output logic       wrap,
  output logic       tick
);

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          sync1;
  logic          sync2;
  logic          btn_cond;
  logic          btn_prev;
  logic          press;
  logic          step;
  logic [3:0]    nu;
  logic [3:0]    nd;
  logic [3:0]    nc;
  logic          nw;

  assign tick = run && !reset_reset
             && (presc == PMAX);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= step_btn_n;
      sync2 <= sync1;
    end
  end

`ifdef BCD_EVENT_COUNTER_DEBOUNCE_EN
  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DMAX =
    DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] db_cnt;

  // Any return to the held level restarts the stability count.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      db_cnt   <= '0;
      btn_cond <= 1'b1;
    end else if (sync2 == btn_cond) begin
      db_cnt   <= '0;
    end else if (db_cnt == DMAX) begin
      db_cnt   <= '0;
      btn_cond <= sync2;
    end else begin
      db_cnt   <= db_cnt + DW'(1);
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^DEBOUNCE_CYCLES;
  assign btn_cond   = sync2;
`endif

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      btn_prev <= 1'b1;
    end else begin
      btn_prev <= btn_cond;
    end
  end

  assign press = btn_prev && !btn_cond;
  assign step  = tick || press;

  always_comb begin
    nu = unites;
    nd = dizaines;
    nc = centaines;
    nw = 1'b0;
    if (up_down) begin
      if (unites >= 4'd9) begin
        nu = 4'd0;
        if (dizaines >= 4'd9) begin
          nd = 4'd0;
          if (centaines >= 4'd9) begin
            nc = 4'd0;
            nw = 1'b1;
          end else begin
            nc = centaines + 4'd1;
          end
        end else begin
          nd = dizaines + 4'd1;
        end
      end else begin
        nu = unites + 4'd1;
      end
    end else begin
      if (unites == 4'd0) begin
        nu = 4'd9;
        if (dizaines == 4'd0) begin
          nd = 4'd9;
          if (centaines == 4'd0) begin
            nc = 4'd9;
            nw = 1'b1;
          end else begin
            nc = centaines - 4'd1;
          end
        end else begin
          nd = dizaines - 4'd1;
        end
      end else begin
        nu = unites - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      presc     <= '0;
      unites    <= 4'd0;
      dizaines  <= 4'd0;
      centaines <= 4'd0;
      wrap      <= 1'b0;
    end else if (clear) begin
      presc     <= '0;
      unites    <= 4'd0;
      dizaines  <= 4'd0;
      centaines <= 4'd0;
      wrap      <= 1'b0;
    end else begin
      unique case (1'b1)
        !run:           presc <= '0;
        presc == PMAX:  presc <= '0;
        default:        presc <= presc + PW'(1);
      endcase
      wrap <= 1'b0;
      if (step) begin
        unites    <= nu;
        dizaines  <= nd;
        centaines <= nc;
        wrap      <= nw;
      end
    end
  end

endmodule
